// File: rtl/fir_pkg.sv
// Shared definitions for the FIR band sequencer, filter and coefficient ROM.
package fir_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int TAPS_DEF  = 1021;
  localparam int DEPTH_DEF = 1024;
  localparam int AW_DEF    = 10;
  localparam int DRAIN_DEF = 2;

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// Sample-strobe / queue-address / filter-control bundle of one FIR band.
interface fir_seq_ctrl_if #(
  parameter int AW = 10
);
  logic          smpl_vld;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          sequencing;
  logic          out_vld;
  logic          busy;
  logic          full;
  logic          overrun;

  // Codec / system side: presents samples, observes status.
  modport master (
    output smpl_vld,
    input  wr_en, wr_addr, rd_addr, sequencing, out_vld, busy, full, overrun
  );

  // Sequencer side.
  modport slave (
    input  smpl_vld,
    output wr_en, wr_addr, rd_addr, sequencing, out_vld, busy, full, overrun
  );
endinterface

// File: rtl/fir_queue_ptr.sv
// Circular sample-queue write pointer and fill tracking.
// fill_cnt saturates at TAPS; once full, the queue always holds a whole
// filter window behind the write pointer.
module fir_queue_ptr #(
  parameter int TAPS  = 1021,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          smpl_vld,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] wr_ptr_next,
  output logic          full,
  output logic          full_next
);
  localparam int FW = $clog2(TAPS + 1);

  logic [AW-1:0] wr_ptr_r;
  logic [FW-1:0] fill_cnt_r;
  logic [FW-1:0] fill_next_s;
  logic          full_r;

  // Next write pointer and saturating fill count for this cycle's sample.
  always_comb begin
    wr_ptr_next = wr_ptr_r;
    fill_next_s = fill_cnt_r;
    if (smpl_vld) begin
      if (wr_ptr_r == AW'(DEPTH - 1)) begin
        wr_ptr_next = '0;
      end else begin
        wr_ptr_next = wr_ptr_r + AW'(1);
      end
      if (fill_cnt_r != FW'(TAPS)) begin
        fill_next_s = fill_cnt_r + FW'(1);
      end else begin
        fill_next_s = fill_cnt_r;
      end
    end else begin
      wr_ptr_next = wr_ptr_r;
      fill_next_s = fill_cnt_r;
    end
  end

  assign full_next = (fill_next_s == FW'(TAPS));

  // Pointer, fill count and sticky full flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= '0;
      fill_cnt_r <= '0;
      full_r     <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_next;
      fill_cnt_r <= fill_next_s;
      full_r     <= full_next;
    end
  end

  assign wr_ptr = wr_ptr_r;
  assign full   = full_r;
endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR band sequencer: walks the read address over the last TAPS samples
// once per incoming sample, then waits out the pipeline and flags out_vld.
// One sample arriving during a run is remembered (pend); a second one is
// an overrun.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int TAPS  = TAPS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DRAIN = DRAIN_DEF
) (
  input logic           clk,
  input logic           rst_n,
  fir_seq_ctrl_if.slave bus
);
  localparam int KW = (TAPS < 2) ? 1 : $clog2(TAPS);
  localparam int DW = (DRAIN < 2) ? 1 : $clog2(DRAIN);

  state_e        state_r;
  logic [KW-1:0] k_r;
  logic [DW-1:0] drain_cnt_r;
  logic [AW-1:0] rd_addr_r;
  logic          seq_r;
  logic          out_vld_r;
  logic          pend_r;
  logic          overrun_r;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_next;
  logic          full;
  logic          full_next;
  logic          busy_s;
  logic          start_s;

  fir_queue_ptr #(
    .TAPS  (TAPS),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_queue_ptr (
    .clk         (clk),
    .rst_n       (rst_n),
    .smpl_vld    (bus.smpl_vld),
    .wr_ptr      (wr_ptr),
    .wr_ptr_next (wr_ptr_next),
    .full        (full),
    .full_next   (full_next)
  );

  assign busy_s  = (state_r != S_IDLE);
  assign start_s = (bus.smpl_vld || pend_r) && full_next;

  // Sequencer FSM with run/drain counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      k_r         <= '0;
      drain_cnt_r <= '0;
      rd_addr_r   <= '0;
      seq_r       <= 1'b0;
      out_vld_r   <= 1'b0;
      pend_r      <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      out_vld_r <= 1'b0;
      // A sample landing mid-run is queued; a second one is lost.
      if (busy_s && bus.smpl_vld) begin
        pend_r <= 1'b1;
        if (pend_r) begin
          overrun_r <= 1'b1;
        end
      end
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            // Oldest sample of the window, counting the one written now.
            rd_addr_r <= wr_ptr_next - AW'(TAPS);
            k_r       <= '0;
            pend_r    <= 1'b0;
            seq_r     <= 1'b1;
            state_r   <= S_RUN;
          end
        end
        S_RUN: begin
          rd_addr_r <= rd_addr_r + AW'(1);
          if (k_r == KW'(TAPS - 1)) begin
            k_r         <= '0;
            seq_r       <= 1'b0;
            drain_cnt_r <= '0;
            state_r     <= S_DRAIN;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt_r == DW'(DRAIN - 1)) begin
            out_vld_r <= 1'b1;
            state_r   <= S_IDLE;
          end else begin
            drain_cnt_r <= drain_cnt_r + DW'(1);
          end
        end
        default: begin
          seq_r   <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.wr_en      = bus.smpl_vld;
  assign bus.wr_addr    = wr_ptr;
  assign bus.rd_addr    = rd_addr_r;
  assign bus.sequencing = seq_r;
  assign bus.out_vld    = out_vld_r;
  assign bus.busy       = busy_s;
  assign bus.full       = full;
  assign bus.overrun    = overrun_r;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: a small (TAPS=4, DEPTH=8) and a default-sized
// instance, both checked every cycle against an event-schedule model.
module tb_fir_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_seq_ctrl_if #(.AW(3))  if_s ();
  fir_seq_ctrl_if #(.AW(10)) if_d ();

  fir_seq_ctrl #(.TAPS(4), .DEPTH(8), .AW(3), .DRAIN(2)) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s)
  );

  fir_seq_ctrl u_dflt (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_d)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model: samples written since reset, and the schedule of the
  // current run (start cycle s: sequencing in s+1..s+T, out_vld at s+T+D+1).
  int m_taps[2]  = '{4, 1021};
  int m_depth[2] = '{8, 1024};
  int m_drain[2] = '{2, 2};
  int m_cnt[2], m_s[2], m_base[2];
  bit m_act[2], m_pend[2], m_ovr[2];
  int cyc = 0;

  int d_seq_len, d_first_rd, d_out_cyc;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_s[i] = 0; m_base[i] = 0;
      m_act[i] = 1'b0; m_pend[i] = 1'b0; m_ovr[i] = 1'b0;
    end
  endfunction

  task automatic check_cycle(input int i, input bit v, input logic wen, input int wa, input int ra,
                             input logic sq, input logic ov, input logic bz, input logic fl,
                             input logic orun);
    int t, d, rel;
    bit e_seq, e_busy, e_out;
    string p;
    t = m_taps[i]; d = m_drain[i];
    rel = cyc - m_s[i];
    e_seq  = m_act[i] && rel >= 1 && rel <= t;
    e_busy = m_act[i] && rel >= 1 && rel <= t + d;
    e_out  = m_act[i] && rel == t + d + 1;
    p = (i == 0) ? "s" : "d";
    check_eq({p, "_wr_en"},   32'(wen), 32'(v));
    check_eq({p, "_wr_addr"}, 32'(wa),  32'(m_cnt[i] % m_depth[i]));
    check_eq({p, "_full"},    32'(fl),  32'(m_cnt[i] >= t));
    check_eq({p, "_overrun"}, 32'(orun), 32'(m_ovr[i]));
    check_eq({p, "_seq"},     32'(sq),  32'(e_seq));
    check_eq({p, "_out_vld"}, 32'(ov),  32'(e_out));
    check_eq({p, "_busy"},    32'(bz),  32'(e_busy));
    if (e_seq) check_eq({p, "_rd_addr"}, 32'(ra), 32'((m_base[i] + rel - 1) % m_depth[i]));
    // advance the model past this cycle's clock edge
    m_cnt[i] += int'(v);
    if (e_out) m_act[i] = 1'b0;
    if (e_busy && v) begin
      if (m_pend[i]) m_ovr[i] = 1'b1;
      m_pend[i] = 1'b1;
    end else if (!e_busy && (v || m_pend[i]) && m_cnt[i] >= t) begin
      m_act[i]  = 1'b1;
      m_s[i]    = cyc;
      m_base[i] = (m_cnt[i] - t) % m_depth[i];
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic step(input bit v0, input bit v1);
    @(posedge clk);
    #1;
    if_s.smpl_vld = v0;
    if_d.smpl_vld = v1;
    @(negedge clk);
    check_cycle(0, v0, if_s.wr_en, int'(if_s.wr_addr), int'(if_s.rd_addr), if_s.sequencing,
                if_s.out_vld, if_s.busy, if_s.full, if_s.overrun);
    check_cycle(1, v1, if_d.wr_en, int'(if_d.wr_addr), int'(if_d.rd_addr), if_d.sequencing,
                if_d.out_vld, if_d.busy, if_d.full, if_d.overrun);
    if (if_d.sequencing) begin
      if (d_first_rd < 0) d_first_rd = int'(if_d.rd_addr);
      d_seq_len++;
    end
    if (if_d.out_vld && d_out_cyc < 0) d_out_cyc = cyc;
    cyc++;
  endtask

  task automatic reset_check();
    check_eq("rst_s_wr_addr", 32'(if_s.wr_addr), 32'd0);
    check_eq("rst_s_rd_addr", 32'(if_s.rd_addr), 32'd0);
    check_eq("rst_s_full",    32'(if_s.full),    32'd0);
    check_eq("rst_s_seq",     32'(if_s.sequencing), 32'd0);
    check_eq("rst_s_out_vld", 32'(if_s.out_vld), 32'd0);
    check_eq("rst_s_overrun", 32'(if_s.overrun), 32'd0);
    check_eq("rst_s_busy",    32'(if_s.busy),    32'd0);
    check_eq("rst_d_wr_addr", 32'(if_d.wr_addr), 32'd0);
    check_eq("rst_d_seq",     32'(if_d.sequencing), 32'd0);
    check_eq("rst_d_full",    32'(if_d.full),    32'd0);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    if_s.smpl_vld = 1'b0;
    if_d.smpl_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_check();
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int c0;
    if_s.smpl_vld = 1'b0;
    if_d.smpl_vld = 1'b0;
    model_reset();
    d_seq_len = 0; d_first_rd = -1; d_out_cyc = -1;
    #12;
    reset_check();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // partial fill, then reset
    repeat (3) begin step(1'b1, 1'b0); repeat (9) step(1'b0, 1'b0); end
    do_reset();

    // first run, then one run per sample through the address wrap
    repeat (10) begin step(1'b1, 1'b0); repeat (9) step(1'b0, 1'b0); end

    // one sample during a run: queued, no overrun
    step(1'b1, 1'b0); repeat (2) step(1'b0, 1'b0); step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);

    // two samples during one run: overrun, one extra run
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);

    // reset in the middle of a run
    step(1'b1, 1'b0); repeat (2) step(1'b0, 1'b0);
    do_reset();

    // refill, then a sample coinciding with out_vld
    repeat (4) step(1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);

    // default instance fill, random traffic on the small one
    repeat (1021) step($urandom_range(0, 5) == 0, 1'b1);
    repeat (1100) step($urandom_range(0, 5) == 0, 1'b0);

    // one clean default-size run, measured directly
    d_seq_len = 0; d_first_rd = -1; d_out_cyc = -1;
    c0 = cyc;
    step($urandom_range(0, 5) == 0, 1'b1);
    repeat (1100) step($urandom_range(0, 5) == 0, 1'b0);
    check_eq("dflt_seq_len",  32'(d_seq_len), 32'd1021);
    check_eq("dflt_first_rd", 32'(d_first_rd), 32'((1022 - 1021) % 1024));
    check_eq("dflt_latency",  32'(d_out_cyc - c0), 32'd1024);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
